// File: rtl/cic_fir_decim_pkg.sv
// Shared constants for the CIC compensating FIR decimator: coefficient table,
// MAC sequencer state encoding and a constant-foldable clog2.
package cic_fir_pkg;

  localparam int COEF_TAPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ROUND = 2'd3
  } fir_state_e;

  // Symmetric Q1.17 compensator; taps beyond the table read as zero.
  localparam logic signed [17:0] COEF_TABLE [COEF_TAPS] = '{
    -18'sd120,  -18'sd260,  -18'sd310,  -18'sd150,   18'sd280,   18'sd820,
     18'sd1040,  18'sd420,  -18'sd1180, -18'sd3100, -18'sd3900, -18'sd1600,
     18'sd4800,  18'sd15200, 18'sd26500, 18'sd34000, 18'sd34000, 18'sd26500,
     18'sd15200, 18'sd4800, -18'sd1600, -18'sd3900, -18'sd3100, -18'sd1180,
     18'sd420,   18'sd1040,  18'sd820,   18'sd280,  -18'sd150,  -18'sd310,
    -18'sd260,  -18'sd120
  };

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cic_fir_decim_if.sv
// Sample stream in from the CIC, filtered stream and overrun flag out.
interface cic_fir_decim_if #(
  parameter int IN_WIDTH  = 20,
  parameter int OUT_WIDTH = 24
);
  logic                        in_strobe;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        out_strobe;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        overrun;

  modport master (output in_strobe, in_data, input out_strobe, out_data, overrun);
  modport slave  (input in_strobe, in_data, output out_strobe, out_data, overrun);
endinterface

// File: rtl/cic_fir_coef_rom.sv
// Coefficient lookup with a registered output so it lines up with the sample RAM read.
module cic_fir_coef_rom
  import cic_fir_pkg::*;
#(
  parameter int TAPS       = 32,
  parameter int COEF_WIDTH = 18,
  parameter int IDX_W      = clog2(TAPS)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [IDX_W-1:0]             idx_i,
  output logic signed [COEF_WIDTH-1:0] coef_o
);

  logic signed [COEF_WIDTH-1:0] rom [TAPS];
  logic signed [COEF_WIDTH-1:0] coef_q;

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_rom
    if (gi < COEF_TAPS) begin : g_tab
      assign rom[gi] = COEF_WIDTH'(COEF_TABLE[gi]);
    end else begin : g_zero
      assign rom[gi] = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) coef_q <= '0;
    else          coef_q <= rom[idx_i];
  end

  assign coef_o = coef_q;

endmodule

// File: rtl/cic_fir_decim.sv
// Decimating FIR after the CIC: circular sample buffer, one shared multiplier,
// sequential MAC with round-half-up and saturation on the output.
module cic_fir_decim
  import cic_fir_pkg::*;
#(
  parameter int IN_WIDTH   = 20,
  parameter int COEF_WIDTH = 18,
  parameter int TAPS       = 32,
  parameter int DECIMATION = 2,
  parameter int BUF_AW     = 6,
  parameter int ACC_WIDTH  = IN_WIDTH + COEF_WIDTH + 8,
  parameter int OUT_SHIFT  = 17,
  parameter int OUT_WIDTH  = 24
) (
  input  logic           clock,
  input  logic           reset_n,
  cic_fir_decim_if.slave bus
);

  localparam int KW     = clog2(TAPS);
  localparam int FW     = clog2(TAPS + 1);
  localparam int PW     = clog2(DECIMATION + 1);
  localparam int PROD_W = IN_WIDTH + COEF_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((longint'(1) << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ~SAT_HI;

  fir_state_e                   state_q, state_d;
  logic [KW-1:0]                k_q, k_d;
  logic [BUF_AW-1:0]            wr_ptr_q, wr_ptr_d, base_q, rd_addr;
  logic [PW-1:0]                phase_q, phase_d;
  logic [FW-1:0]                fill_q, fill_d, fill_run_q;
  logic                         rd_vld_q, rd_first_q, rd_mask_q;
  logic                         mul_vld_q, mul_first_q;
  logic signed [IN_WIDTH-1:0]   rd_data_q;
  logic signed [COEF_WIDTH-1:0] coef;
  logic signed [PROD_W-1:0]     prod_q;
  logic signed [ACC_WIDTH-1:0]  acc_q, shifted, rnd;
  logic                         out_strobe_q, overrun_q;
  logic signed [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                         trig, accept;

  logic signed [IN_WIDTH-1:0] mem [1 << BUF_AW];

  assign trig    = bus.in_strobe && (phase_q == PW'(DECIMATION - 1));
  // A trigger landing on the ROUND cycle starts the next run back-to-back.
  assign accept  = trig && (state_q == ST_IDLE || state_q == ST_ROUND);
  assign rd_addr = base_q - BUF_AW'(k_q);

  always_comb begin
    state_d  = state_q;
    k_d      = '0;
    wr_ptr_d = bus.in_strobe ? wr_ptr_q + BUF_AW'(1) : wr_ptr_q;
    phase_d  = phase_q;
    fill_d   = fill_q;
    if (bus.in_strobe) begin
      phase_d = (phase_q == PW'(DECIMATION - 1)) ? '0 : phase_q + PW'(1);
      if (fill_q != FW'(TAPS)) fill_d = fill_q + FW'(1);
    end
    case (state_q)
      ST_IDLE:  if (trig) state_d = ST_RUN;
      ST_RUN: begin
        k_d = k_q + KW'(1);
        if (k_q == KW'(TAPS - 1)) begin
          state_d = ST_DRAIN;
          k_d     = '0;
        end
      end
      ST_DRAIN: begin
        k_d = k_q + KW'(1);
        if (k_q == KW'(1)) begin
          state_d = ST_ROUND;
          k_d     = '0;
        end
      end
      ST_ROUND: state_d = trig ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign shifted = acc_q >>> OUT_SHIFT;
  assign rnd     = shifted + {{(ACC_WIDTH-1){1'b0}}, acc_q[OUT_SHIFT-1]};

  always_comb begin
    out_data_d = rnd[OUT_WIDTH-1:0];
    if (rnd > SAT_HI)      out_data_d = SAT_HI[OUT_WIDTH-1:0];
    else if (rnd < SAT_LO) out_data_d = SAT_LO[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (bus.in_strobe) mem[wr_ptr_q] <= bus.in_data;
    rd_data_q <= mem[rd_addr];
  end

  cic_fir_coef_rom #(
    .TAPS       (TAPS),
    .COEF_WIDTH (COEF_WIDTH),
    .IDX_W      (KW)
  ) u_coef_rom (
    .clock   (clock),
    .reset_n (reset_n),
    .idx_i   (k_q),
    .coef_o  (coef)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      wr_ptr_q     <= '0;
      phase_q      <= '0;
      fill_q       <= '0;
      base_q       <= '0;
      fill_run_q   <= '0;
      rd_vld_q     <= 1'b0;
      rd_first_q   <= 1'b0;
      rd_mask_q    <= 1'b0;
      mul_vld_q    <= 1'b0;
      mul_first_q  <= 1'b0;
      prod_q       <= '0;
      acc_q        <= '0;
      out_strobe_q <= 1'b0;
      out_data_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      wr_ptr_q <= wr_ptr_d;
      phase_q  <= phase_d;
      fill_q   <= fill_d;
      if (accept) begin
        base_q     <= wr_ptr_q;
        fill_run_q <= fill_d;
      end
      if (trig && !accept) overrun_q <= 1'b1;
      // Taps older than the samples written since reset are forced to zero.
      rd_vld_q    <= (state_q == ST_RUN);
      rd_first_q  <= (state_q == ST_RUN) && (k_q == '0);
      rd_mask_q   <= (FW'(k_q) >= fill_run_q);
      mul_vld_q   <= rd_vld_q;
      mul_first_q <= rd_first_q;
      prod_q      <= rd_mask_q ? '0 : PROD_W'(rd_data_q) * PROD_W'(coef);
      if (mul_vld_q)
        acc_q <= mul_first_q ? ACC_WIDTH'(prod_q) : acc_q + ACC_WIDTH'(prod_q);
      out_strobe_q <= (state_q == ST_ROUND);
      if (state_q == ST_ROUND) out_data_q <= out_data_d;
    end
  end

  assign bus.out_strobe = out_strobe_q;
  assign bus.out_data   = out_data_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_cic_fir_decim.sv
// Random-stimulus bench for cic_fir_decim: two instances (24-bit and 20-bit output)
// scored against a sample-history model of the decimating FIR.
module tb_cic_fir_decim;
  import cic_fir_pkg::*;

  localparam int TAPS = 32;
  localparam int DEC  = 2;
  localparam int LAT  = TAPS + 3;  // edges from trigger edge to the edge that raises out_strobe

  typedef struct {
    longint due;
    longint acc;
  } exp_t;

  logic   clock = 1'b0;
  logic   reset_n = 1'b0;
  int     n_checks = 0;
  int     n_pass = 0;
  longint edge_cnt = 0;
  longint hist[$];
  int     n_samp;
  longint last_acc;
  bit     exp_ovr;
  exp_t   expq[$];

  always #5 clock = ~clock;

  cic_fir_decim_if #(.IN_WIDTH(20), .OUT_WIDTH(24)) bus_a ();
  cic_fir_decim_if #(.IN_WIDTH(20), .OUT_WIDTH(20)) bus_b ();

  cic_fir_decim #(
    .IN_WIDTH(20), .COEF_WIDTH(18), .TAPS(TAPS), .DECIMATION(DEC), .BUF_AW(6),
    .ACC_WIDTH(46), .OUT_SHIFT(17), .OUT_WIDTH(24)
  ) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  cic_fir_decim #(
    .IN_WIDTH(20), .COEF_WIDTH(18), .TAPS(TAPS), .DECIMATION(DEC), .BUF_AW(6),
    .ACC_WIDTH(46), .OUT_SHIFT(17), .OUT_WIDTH(20)
  ) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_cnt);
  endtask

  function automatic longint round_sat(input longint acc, input int ow);
    longint r, hi;
    r  = (acc >>> 17) + ((acc >>> 16) & 1);
    hi = (longint'(1) << (ow - 1)) - 1;
    if (r > hi) r = hi;
    if (r < -hi - 1) r = -hi - 1;
    return r;
  endfunction

  function automatic longint rand_sample();
    logic signed [19:0] r;
    r = 20'($urandom);
    return longint'(r);
  endfunction

  task automatic model_strobe(input longint x);
    longint acc;
    exp_t   e;
    hist.push_back(x);
    n_samp++;
    if (n_samp % DEC == 0) begin
      if (edge_cnt >= last_acc + LAT) begin
        acc = 0;
        for (int k = 0; k < TAPS; k++)
          if (k < n_samp) acc += longint'(COEF_TABLE[k]) * hist[n_samp - 1 - k];
        e.due = edge_cnt + LAT;
        e.acc = acc;
        expq.push_back(e);
        last_acc = edge_cnt;
      end else begin
        exp_ovr = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input bit strobe_in);
    bit exp_s;
    exp_s = (expq.size() > 0) && (expq[0].due == edge_cnt);
    if (bus_a.out_strobe || bus_b.out_strobe || exp_s) begin
      check_val("strobe_a", longint'(bus_a.out_strobe), longint'(exp_s));
      check_val("strobe_b", longint'(bus_b.out_strobe), longint'(exp_s));
      if (exp_s) begin
        check_val("data_a", longint'(bus_a.out_data), round_sat(expq[0].acc, 24));
        check_val("data_b", longint'(bus_b.out_data), round_sat(expq[0].acc, 20));
        void'(expq.pop_front());
      end
    end
    if (strobe_in || exp_s) begin
      check_val("overrun_a", longint'(bus_a.overrun), longint'(exp_ovr));
      check_val("overrun_b", longint'(bus_b.overrun), longint'(exp_ovr));
    end
  endtask

  task automatic step(input bit s, input longint x);
    bus_a.in_strobe = s;
    bus_b.in_strobe = s;
    bus_a.in_data   = x[19:0];
    bus_b.in_data   = x[19:0];
    @(posedge clock);
    edge_cnt++;
    if (s) model_strobe(x);
    #1;
    check_outputs(s);
  endtask

  task automatic send(input longint x, input int gap);
    step(1'b1, x);
    for (int i = 1; i < gap; i++) step(1'b0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 5; i++) step(1'b0, 0);
    check_val("pending_outputs", longint'(expq.size()), 0);
  endtask

  task automatic do_reset(input int cycles);
    bus_a.in_strobe = 1'b0;
    bus_b.in_strobe = 1'b0;
    reset_n = 1'b0;
    #1;
    check_val("rst_strobe_a", longint'(bus_a.out_strobe), 0);
    check_val("rst_data_a", longint'(bus_a.out_data), 0);
    check_val("rst_overrun_a", longint'(bus_a.overrun), 0);
    check_val("rst_strobe_b", longint'(bus_b.out_strobe), 0);
    check_val("rst_data_b", longint'(bus_b.out_data), 0);
    check_val("rst_overrun_b", longint'(bus_b.overrun), 0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      edge_cnt++;
    end
    #1;
    reset_n  = 1'b1;
    hist.delete();
    expq.delete();
    n_samp   = 0;
    exp_ovr  = 1'b0;
    last_acc = -1000;
  endtask

  initial begin
    bus_a.in_strobe = 1'b0;
    bus_b.in_strobe = 1'b0;
    bus_a.in_data   = '0;
    bus_b.in_data   = '0;
    #1;
    do_reset(3);

    // Impulse of 2^17: outputs walk the odd-indexed coefficients
    send(131072, 40);
    for (int i = 0; i < 33; i++) send(0, 40);
    drain();

    // DC level
    do_reset(2);
    for (int i = 0; i < 64; i++) send(100000, 40);
    drain();

    // Triggers 20 cycles apart: every other one is dropped
    do_reset(2);
    for (int i = 0; i < 8; i++) send(rand_sample(), 10);
    check_val("overrun_set_a", longint'(bus_a.overrun), 1);
    check_val("overrun_set_b", longint'(bus_b.overrun), 1);
    drain();

    // Random data, random spacing
    do_reset(2);
    for (int i = 0; i < 120; i++) send(rand_sample(), int'($urandom_range(8, 30)));
    drain();

    // Full-scale inputs matched to coefficient signs, then inverted
    do_reset(2);
    for (int i = 0; i < 32; i++) send((COEF_TABLE[31 - i] < 0) ? -524287 : 524287, 20);
    for (int i = 32; i < 64; i++) send((COEF_TABLE[63 - i] < 0) ? 524287 : -524287, 20);
    drain();

    // Reset 10 cycles into a run, then a two-sample fill-masked output
    do_reset(2);
    send(rand_sample(), 5);
    step(1'b1, rand_sample());
    for (int i = 0; i < 9; i++) step(1'b0, 0);
    do_reset(2);
    send(rand_sample(), 5);
    send(rand_sample(), 40);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
